// File: rtl/top_q_pkg.sv
// -----------------------------------------------------------------------------
// top_q_pkg
// Shared constants and types for the q = floor(((a-b)*(1+3c) - 4d) / 2)
// streaming unit.
//   DATA_WIDTH : default operand/result width (two's complement)
//   LATENCY    : clock edges from the launch edge to the q_valid_o pulse
//   data_t     : signed operand/result word
// -----------------------------------------------------------------------------
package top_q_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int LATENCY    = 4;

    typedef logic signed [DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/top_q_if.sv
// -----------------------------------------------------------------------------
// top_q_if
// Operand and result stream bundle for top_q_calc.
//   a_i..d_i             : signed operands
//   a_valid_i..d_valid_i : per-operand valid strobes
//   q_o                  : signed result, holds the last result
//   q_valid_o            : one-cycle pulse per result
// master : the operand source / result sink
// slave  : the compute block
// -----------------------------------------------------------------------------
interface top_q_if
    import top_q_pkg::*;
#(
    parameter int DATA_WIDTH = top_q_pkg::DATA_WIDTH
);

    logic signed [DATA_WIDTH-1:0] a_i;
    logic signed [DATA_WIDTH-1:0] b_i;
    logic signed [DATA_WIDTH-1:0] c_i;
    logic signed [DATA_WIDTH-1:0] d_i;
    logic                         a_valid_i;
    logic                         b_valid_i;
    logic                         c_valid_i;
    logic                         d_valid_i;
    logic signed [DATA_WIDTH-1:0] q_o;
    logic                         q_valid_o;

    modport master (
        output a_i, b_i, c_i, d_i,
        output a_valid_i, b_valid_i, c_valid_i, d_valid_i,
        input  q_o, q_valid_o
    );

    modport slave (
        input  a_i, b_i, c_i, d_i,
        input  a_valid_i, b_valid_i, c_valid_i, d_valid_i,
        output q_o, q_valid_o
    );

endinterface

// File: rtl/top_q_join.sv
// -----------------------------------------------------------------------------
// top_q_join
// Joins four independently-valid operand streams into one operand set.
// Each operand has a hold register and a full flag. A set launches on the
// first edge where every operand is either held or arriving; arriving values
// win over held ones. Launch clears all full flags, so an operand arriving on
// the launch edge is consumed by that set.
//   clk_i, artsn_i        : clock, async active-low reset
//   i_a..i_d, i_*_valid   : operand streams
//   o_launch              : registered one-cycle launch strobe
//   o_a..o_d              : operand set aligned with o_launch
// -----------------------------------------------------------------------------
module top_q_join
    import top_q_pkg::*;
#(
    parameter int DATA_WIDTH = top_q_pkg::DATA_WIDTH
) (
    input  logic                         clk_i,
    input  logic                         artsn_i,
    input  logic signed [DATA_WIDTH-1:0] i_a,
    input  logic signed [DATA_WIDTH-1:0] i_b,
    input  logic signed [DATA_WIDTH-1:0] i_c,
    input  logic signed [DATA_WIDTH-1:0] i_d,
    input  logic                         i_a_valid,
    input  logic                         i_b_valid,
    input  logic                         i_c_valid,
    input  logic                         i_d_valid,
    output logic                         o_launch,
    output logic signed [DATA_WIDTH-1:0] o_a,
    output logic signed [DATA_WIDTH-1:0] o_b,
    output logic signed [DATA_WIDTH-1:0] o_c,
    output logic signed [DATA_WIDTH-1:0] o_d
);

    logic signed [DATA_WIDTH-1:0] r_hold_a;
    logic signed [DATA_WIDTH-1:0] r_hold_b;
    logic signed [DATA_WIDTH-1:0] r_hold_c;
    logic signed [DATA_WIDTH-1:0] r_hold_d;
    logic [3:0]                   r_full;      // {d, c, b, a}
    logic                         r_launch;
    logic signed [DATA_WIDTH-1:0] r_a;
    logic signed [DATA_WIDTH-1:0] r_b;
    logic signed [DATA_WIDTH-1:0] r_c;
    logic signed [DATA_WIDTH-1:0] r_d;

    logic [3:0]                   w_valid;
    logic                         w_launch;
    logic signed [DATA_WIDTH-1:0] w_a;
    logic signed [DATA_WIDTH-1:0] w_b;
    logic signed [DATA_WIDTH-1:0] w_c;
    logic signed [DATA_WIDTH-1:0] w_d;

    always_comb begin
        w_valid  = {i_d_valid, i_c_valid, i_b_valid, i_a_valid};
        w_launch = &(w_valid | r_full);
        // Arriving operand takes priority over the held copy.
        w_a      = i_a_valid ? i_a : r_hold_a;
        w_b      = i_b_valid ? i_b : r_hold_b;
        w_c      = i_c_valid ? i_c : r_hold_c;
        w_d      = i_d_valid ? i_d : r_hold_d;
    end

    always_ff @(posedge clk_i or negedge artsn_i) begin
        if (!artsn_i) begin
            r_hold_a <= '0;
            r_hold_b <= '0;
            r_hold_c <= '0;
            r_hold_d <= '0;
            r_full   <= '0;
            r_launch <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= '0;
            r_d      <= '0;
        end else begin
            // Hold registers just track the latest arrival; the full flags
            // decide whether the held value is still owed to a future set.
            if (i_a_valid) r_hold_a <= i_a;
            if (i_b_valid) r_hold_b <= i_b;
            if (i_c_valid) r_hold_c <= i_c;
            if (i_d_valid) r_hold_d <= i_d;

            r_launch <= w_launch;
            if (w_launch) begin
                r_full <= '0;
                r_a    <= w_a;
                r_b    <= w_b;
                r_c    <= w_c;
                r_d    <= w_d;
            end else begin
                r_full <= r_full | w_valid;
            end
        end
    end

    assign o_launch = r_launch;
    assign o_a      = r_a;
    assign o_b      = r_b;
    assign o_c      = r_c;
    assign o_d      = r_d;

endmodule

// File: rtl/top_q_calc.sv
// -----------------------------------------------------------------------------
// top_q_calc
// Streaming signed unit: q = floor(((a-b)*(1+3c) - 4d) / 2), all
// intermediates wrapping at DATA_WIDTH bits. One result per clock; the pulse
// on q_valid_o follows the launch edge by LATENCY edges.
//   clk_i   : clock, rising edge
//   artsn_i : async active-low reset
//   bus     : operand/result streams (top_q_if.slave)
// Pipeline: join (launch reg) -> S1 diff/m/d4 -> S2 prod -> S3 x -> S4 q.
// -----------------------------------------------------------------------------
module top_q_calc
    import top_q_pkg::*;
#(
    parameter int DATA_WIDTH = top_q_pkg::DATA_WIDTH
) (
    input  logic    clk_i,
    input  logic    artsn_i,
    top_q_if.slave  bus
);

    logic                         w_launch;
    logic signed [DATA_WIDTH-1:0] w_a;
    logic signed [DATA_WIDTH-1:0] w_b;
    logic signed [DATA_WIDTH-1:0] w_c;
    logic signed [DATA_WIDTH-1:0] w_d;

    // Stage valids after the launch register: [0]=S1, [1]=S2, [2]=S3.
    logic [LATENCY-2:0]           r_vld;

    logic signed [DATA_WIDTH-1:0] r_diff;
    logic signed [DATA_WIDTH-1:0] r_m;
    logic signed [DATA_WIDTH-1:0] r_d4_s1;
    logic signed [DATA_WIDTH-1:0] r_prod;
    logic signed [DATA_WIDTH-1:0] r_d4_s2;
    logic signed [DATA_WIDTH-1:0] r_x;
    logic signed [DATA_WIDTH-1:0] r_q;
    logic                         r_q_valid;

    top_q_join #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_join (
        .clk_i     (clk_i),
        .artsn_i   (artsn_i),
        .i_a       (bus.a_i),
        .i_b       (bus.b_i),
        .i_c       (bus.c_i),
        .i_d       (bus.d_i),
        .i_a_valid (bus.a_valid_i),
        .i_b_valid (bus.b_valid_i),
        .i_c_valid (bus.c_valid_i),
        .i_d_valid (bus.d_valid_i),
        .o_launch  (w_launch),
        .o_a       (w_a),
        .o_b       (w_b),
        .o_c       (w_c),
        .o_d       (w_d)
    );

    always_ff @(posedge clk_i or negedge artsn_i) begin
        if (!artsn_i) begin
            r_vld     <= '0;
            r_diff    <= '0;
            r_m       <= '0;
            r_d4_s1   <= '0;
            r_prod    <= '0;
            r_d4_s2   <= '0;
            r_x       <= '0;
            r_q       <= '0;
            r_q_valid <= 1'b0;
        end else begin
            r_vld     <= {r_vld[LATENCY-3:0], w_launch};

            // S1: 1+3c built from shift-add so no second multiplier is needed.
            r_diff    <= w_a - w_b;
            r_m       <= w_c + (w_c <<< 1) + DATA_WIDTH'(1);
            r_d4_s1   <= w_d <<< 2;

            // S2: only the low DATA_WIDTH bits of the product are kept.
            r_prod    <= r_diff * r_m;
            r_d4_s2   <= r_d4_s1;

            // S3
            r_x       <= r_prod - r_d4_s2;

            // S4: arithmetic shift gives floor division (-1 -> -1, not 0).
            // q holds its value between results.
            r_q_valid <= r_vld[LATENCY-2];
            if (r_vld[LATENCY-2]) begin
                r_q <= r_x >>> 1;
            end
        end
    end

    assign bus.q_o       = r_q;
    assign bus.q_valid_o = r_q_valid;

endmodule

// File: tb/tb_top_q_calc.sv
module tb_top_q_calc;
    import top_q_pkg::*;

    logic clk_i   = 1'b0;
    logic artsn_i = 1'b0;
    int   cyc     = 0;
    int   n_vec   = 0;
    int   n_miss  = 0;

    data_t q_seen[$];
    int    cyc_seen[$];

    top_q_if #(.DATA_WIDTH(32)) bus ();

    top_q_calc #(.DATA_WIDTH(32)) u_dut (
        .clk_i   (clk_i),
        .artsn_i (artsn_i),
        .bus     (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Record every result pulse together with the edge index that produced it.
    always @(negedge clk_i) begin
        if (artsn_i && bus.q_valid_o === 1'b1) begin
            q_seen.push_back(bus.q_o);
            cyc_seen.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Drive one cycle of operands with valid mask {d,c,b,a}; returns the edge
    // index on which the DUT samples them.
    task automatic apply(input logic [3:0] vmask, input data_t a, input data_t b,
                         input data_t c, input data_t d, output int edge_idx);
        bus.a_i = a; bus.b_i = b; bus.c_i = c; bus.d_i = d;
        bus.a_valid_i = vmask[0];
        bus.b_valid_i = vmask[1];
        bus.c_valid_i = vmask[2];
        bus.d_valid_i = vmask[3];
        tick();
        edge_idx = cyc;
        bus.a_valid_i = 1'b0;
        bus.b_valid_i = 1'b0;
        bus.c_valid_i = 1'b0;
        bus.d_valid_i = 1'b0;
    endtask

    task automatic expect_pulse(input string tag, input data_t exp_q, input int exp_cyc);
        int waited = 0;
        while (q_seen.size() == 0 && waited < 20) begin
            @(negedge clk_i);
            waited++;
        end
        chk({tag, "_present"}, 32'(q_seen.size() != 0), 32'd1);
        if (q_seen.size() != 0) begin
            data_t gq;
            int    gc;
            gq = q_seen.pop_front();
            gc = cyc_seen.pop_front();
            chk({tag, "_q"}, gq, exp_q);
            chk({tag, "_cycle"}, 32'(gc), 32'(exp_cyc));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int    e;
        int    e0;
        int    e1;
        int    e2;
        int    e3;
        data_t exp_b2b [10];

        exp_b2b = '{32'sd0, 32'sd2, 32'sd4, 32'sd6, 32'sd8,
                    32'sd10, 32'sd12, 32'sd14, 32'sd16, 32'sd18};

        bus.a_i = '0; bus.b_i = '0; bus.c_i = '0; bus.d_i = '0;
        bus.a_valid_i = 1'b0; bus.b_valid_i = 1'b0;
        bus.c_valid_i = 1'b0; bus.d_valid_i = 1'b0;

        // Reset state
        idle(2);
        chk("rst_q", bus.q_o, 32'h0);
        chk("rst_qv", 32'(bus.q_valid_o), 32'h0);
        artsn_i = 1'b1;
        idle(2);
        chk("idle_qv", 32'(bus.q_valid_o), 32'h0);

        // Basic: (6*7 - 12)/2 = 15, single pulse, then hold
        apply(4'b1111, 10, 4, 2, 3, e);
        expect_pulse("basic", 32'sd15, e + 4);
        idle(6);
        chk("basic_single", 32'(q_seen.size()), 32'd0);
        chk("basic_hold", bus.q_o, 32'd15);

        // Sign and floor cases, back-to-back
        apply(4'b1111, 0, 5, 1, 0, e0);
        apply(4'b1111, 0, 1, 0, 0, e1);
        apply(4'b1111, 3, 0, 0, 0, e2);
        apply(4'b1111, 1, 0, 0, 0, e3);
        expect_pulse("neg20", -32'sd10, e0 + 4);
        expect_pulse("floor_m1", -32'sd1, e1 + 4);
        expect_pulse("three", 32'sd1, e2 + 4);
        expect_pulse("one", 32'sd0, e3 + 4);

        // Ten sets back-to-back: a=k, b=0, c=1, d=1 -> (4k-4)/2 = 2k-2
        e0 = 0;
        for (int k = 1; k <= 10; k++) begin
            apply(4'b1111, k, 0, 1, 1, e);
            if (k == 1) e0 = e;
        end
        for (int k = 0; k < 10; k++) begin
            expect_pulse($sformatf("b2b%0d", k), exp_b2b[k], e0 + k + 4);
        end
        idle(6);
        chk("b2b_count", 32'(q_seen.size()), 32'd0);

        // Staggered: a, then b+c, then d; undriven lanes carry junk
        apply(4'b0001, 10, 32'shDEAD, 32'shDEAD, 32'shDEAD, e);
        apply(4'b0110, 32'shBEEF, 4, 2, 32'shBEEF, e);
        apply(4'b1000, 32'shCAFE, 32'shCAFE, 32'shCAFE, 3, e);
        expect_pulse("stagger", 32'sd15, e + 4);
        idle(6);
        chk("stagger_single", 32'(q_seen.size()), 32'd0);

        // Overwrite of a held operand before launch
        apply(4'b0001, 99, 0, 0, 0, e);
        apply(4'b0011, 10, 4, 0, 0, e);
        apply(4'b1100, 0, 0, 2, 3, e);
        expect_pulse("overwrite", 32'sd15, e + 4);

        // Wrap: diff = 0x80000000, q = 0xC0000000
        apply(4'b1111, 32'sh7FFFFFFF, -32'sd1, 0, 0, e);
        expect_pulse("wrap", 32'shC0000000, e + 4);
        idle(4);

        // Reset with two sets in flight plus a held operand
        apply(4'b1111, 10, 4, 2, 3, e);
        apply(4'b1111, 3, 0, 0, 0, e);
        apply(4'b0001, 50, 0, 0, 0, e);
        #2;
        artsn_i = 1'b0;
        #1;
        chk("midrst_q", bus.q_o, 32'h0);
        chk("midrst_qv", 32'(bus.q_valid_o), 32'h0);
        idle(2);
        artsn_i = 1'b1;
        idle(8);
        chk("midrst_nopulse", 32'(q_seen.size()), 32'd0);
        chk("midrst_q_after", bus.q_o, 32'h0);

        // Held a was discarded: b,c,d alone must not launch
        apply(4'b1110, 0, 4, 2, 3, e);
        idle(8);
        chk("discard_nolaunch", 32'(q_seen.size()), 32'd0);
        apply(4'b0001, 10, 0, 0, 0, e);
        expect_pulse("post_rst", 32'sd15, e + 4);
        idle(6);
        chk("end_count", 32'(q_seen.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
